// File: rtl/spart_pkg.sv
// ---------------------------------------------------------------------------
// spart_pkg
// Shared definitions for the SPART blocks (receiver, transmitter, bus mux).
//   - I/O address codes decoded from ioaddr
//   - receive FSM state encoding
//   - oversampling constants for the 16x baud tick
// ---------------------------------------------------------------------------
package spart_pkg;

  // Bus register map (ioaddr)
  localparam logic [1:0] IOADDR_DATA   = 2'b00;
  localparam logic [1:0] IOADDR_STATUS = 2'b01;
  localparam logic [1:0] IOADDR_DB_LO  = 2'b10;
  localparam logic [1:0] IOADDR_DB_HI  = 2'b11;

  // brg_en ticks per bit period, and the tick index that lands mid-bit
  // when counting starts at the detected start edge.
  localparam int SPART_OVERSAMPLE = 16;
  localparam int SPART_MID_SAMPLE = 7;

  // Receive FSM states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'b00,
    RX_START = 2'b01,
    RX_DATA  = 2'b10,
    RX_STOP  = 2'b11
  } rx_state_e;

endpackage

// File: rtl/spart_sync.sv
// ---------------------------------------------------------------------------
// spart_sync
// N-stage synchronizer for an asynchronous single-bit input. All stages
// reset to RESET_VAL so an idle-high serial line (or inactive CTS) does not
// look like an edge coming out of reset.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous, active-low reset
//   d    in  asynchronous input
//   q    out synchronized output (STAGES clocks of latency)
// ---------------------------------------------------------------------------
module spart_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spart_rx.sv
// ---------------------------------------------------------------------------
// spart_rx
// SPART serial receiver. Deframes 8N1 async data on rxd (LSB first) using the
// 16x oversample tick brg_en, and holds the byte plus status for the bus.
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-low reset
//   brg_en       in   one-clk pulse every 1/16 bit period
//   rxd          in   async serial line, idle high
//   iocs         in   chip select
//   iorw         in   1 = read, 0 = write
//   ioaddr       in   register address (IOADDR_DATA reads the rx byte)
//   rx_data      out  last received byte
//   rda          out  byte available, not yet read
//   framing_err  out  last completed frame had a low stop bit
//   overrun      out  a byte completed while rda was still set
//   dbg_state    out  current receive FSM state (debug/observability)
// ---------------------------------------------------------------------------
module spart_rx
  import spart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 brg_en,
  input  logic                 rxd,
  input  logic                 iocs,
  input  logic                 iorw,
  input  logic [1:0]           ioaddr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun,
  output rx_state_e            dbg_state
);

  localparam int TICK_W = $clog2(SPART_OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(SPART_MID_SAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SPART_OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic rxd_s;
  logic rd_data;

  rx_state_e             state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rda_q, rda_d;
  logic                  fe_q, fe_d;
  logic                  ovr_q, ovr_d;

  spart_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_rxd_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // Bus handshake: a read of the data register is a single-cycle strobe
  // (rd_data) with no ready/wait. It clears rda and overrun at the next edge.
  // If a frame completes on the same edge, the completion wins: rda stays 1
  // with the new byte, and overrun is 0 because the old byte was consumed by
  // that very read. rx_data and framing_err are never touched by reads.
  assign rd_data = iocs & iorw & (ioaddr == IOADDR_DATA);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    fe_d      = fe_q;
    rda_d     = rda_q & ~rd_data;
    ovr_d     = ovr_q & ~rd_data;

    case (state_q)
      RX_IDLE: begin
        // Re-arms on any low sample, including right after a completion
        // in the second half of the stop bit.
        tick_d = '0;
        if (!rxd_s) begin
          state_d = RX_START;
        end
      end

      RX_START: begin
        if (brg_en) begin
          if (tick_q == TICK_MID) begin
            if (rxd_s) begin
              // Line went back high before mid start bit: treat as noise.
              state_d = RX_IDLE;
            end else begin
              state_d = RX_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      RX_DATA: begin
        if (brg_en) begin
          if (tick_q == TICK_LAST) begin
            // A full bit period after the mid start sample is mid data bit.
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            tick_d  = '0;
            if (bit_q == BIT_LAST) begin
              state_d = RX_STOP;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      RX_STOP: begin
        if (brg_en) begin
          if (tick_q == TICK_LAST) begin
            rx_data_d = shift_q;
            rda_d     = 1'b1;
            fe_d      = ~rxd_s;
            ovr_d     = rda_q & ~rd_data;
            tick_d    = '0;
            state_d   = RX_IDLE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      default: begin
        state_d = RX_IDLE;
        tick_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RX_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      rda_q     <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rda         = rda_q;
  assign framing_err = fe_q;
  assign overrun     = ovr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spart_rx.sv
// ---------------------------------------------------------------------------
// tb_spart_rx
// Bench for spart_rx. brg_en pulses every 4 clks (bit period = 64 clks).
// Frames are described at the byte level; the expected status word
// {rda, overrun, framing_err, rx_data} is derived from a small register
// model and pushed to exp_q. A monitor pops one entry whenever the receiver
// finishes a frame and compares the outputs.
// ---------------------------------------------------------------------------
module tb_spart_rx;
  import spart_pkg::*;

  localparam int W       = 11;
  localparam int BIT_CLK = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       brg_en = 1'b0;
  logic       rxd    = 1'b1;
  logic       iocs   = 1'b0;
  logic       iorw   = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun;
  rx_state_e  dbg_state;

  spart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .brg_en      (brg_en),
    .rxd         (rxd),
    .iocs        (iocs),
    .iorw        (iorw),
    .ioaddr      (ioaddr),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  // brg_en: one pulse every 4 clocks, changed 1 time unit after the edge
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph     = (ph + 1) % 4;
      brg_en = (ph == 0);
    end
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  // Register model of what the bus should see
  logic [7:0] m_data = 8'h00;
  logic       m_rda  = 1'b0;
  logic       m_fe   = 1'b0;
  logic       m_ovr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string name);
    check({name, "_data"}, rx_data, m_data);
    check({name, "_rda"}, rda, m_rda);
    check({name, "_fe"}, framing_err, m_fe);
    check({name, "_ovr"}, overrun, m_ovr);
  endtask

  // ---------------- monitor ----------------
  // A frame is complete when the receiver leaves the stop-bit state.
  initial begin
    rx_state_e prev_state;
    logic [W-1:0] exp_w;
    prev_state = RX_IDLE;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_state = RX_IDLE;
      end else begin
        if (prev_state == RX_STOP && dbg_state != RX_STOP) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {rda, overrun, framing_err, rx_data}, 32'hFFFF_FFFF);
          end else begin
            exp_w = exp_q.pop_front();
            check("frame", {21'd0, rda, overrun, framing_err, rx_data}, {21'd0, exp_w});
          end
        end
        prev_state = dbg_state;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Serialise one 8N1 frame, start edge right after a brg_en edge.
  // Optionally strobe a data-register read on the edge where the stop bit
  // is sampled (9.5 bit periods after the start edge). A low stop bit is
  // cut short right after its mid-sample so the re-armed start detector
  // sees the line go high and rejects it.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit rd_at_done);
    int idx;
    do @(posedge clk); while (brg_en !== 1'b1);
    #1 rxd = 1'b0;
    for (int k = 1; k <= 10 * BIT_CLK; k++) begin
      @(posedge clk);
      #1;
      if (k % BIT_CLK == 0) begin
        idx = k / BIT_CLK;
        if (idx <= 8)       rxd = b[idx-1];
        else if (idx == 9)  rxd = stop_bit;
        else                rxd = 1'b1;
      end
      if (!stop_bit && k == 9 * BIT_CLK + 36) rxd = 1'b1;
      if (rd_at_done && k == 9 * BIT_CLK + BIT_CLK / 2 - 1) begin
        iocs = 1'b1; iorw = 1'b1; ioaddr = IOADDR_DATA;
      end else begin
        iocs = 1'b0; iorw = 1'b0;
      end
    end
    rxd = 1'b1;
  endtask

  // Model a frame, queue its expected status, send it, then confirm the
  // monitor consumed the expectation within the frame time plus a margin.
  task automatic push_frame(input logic [7:0] b, input logic stop_bit, input bit rd_at_done);
    logic ovr;
    ovr    = m_rda & ~rd_at_done;
    m_data = b;
    m_fe   = ~stop_bit;
    m_rda  = 1'b1;
    m_ovr  = ovr;
    exp_q.push_back({1'b1, ovr, ~stop_bit, b});
    send_frame(b, stop_bit, rd_at_done);
    idle_clks(BIT_CLK * 2);
    check("frame_done_in_time", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_read();
    @(posedge clk);
    #1 iocs = 1'b1; iorw = 1'b1; ioaddr = IOADDR_DATA;
    @(posedge clk);
    #1 iocs = 1'b0; iorw = 1'b0;
    m_rda = 1'b0;
    m_ovr = 1'b0;
    check_status("read");
  endtask

  // Bus cycle that must not disturb the receiver (write, or other address)
  task automatic do_access(input logic rw, input logic [1:0] addr);
    @(posedge clk);
    #1 iocs = 1'b1; iorw = rw; ioaddr = addr;
    @(posedge clk);
    #1 iocs = 1'b0; iorw = 1'b0; ioaddr = IOADDR_DATA;
    check_status("no_effect_access");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // reset state
    idle_clks(5);
    #1;
    check_status("reset");
    check("reset_state", dbg_state, RX_IDLE);
    rst = 1'b1;
    idle_clks(10);

    // 1: clean 0xA5
    push_frame(8'hA5, 1'b1, 1'b0);
    do_read();

    // 2: short start glitch is rejected
    @(posedge clk);
    #1 rxd = 1'b0;
    idle_clks(20);
    #1 rxd = 1'b1;
    idle_clks(100);
    #1;
    check("glitch_state", dbg_state, RX_IDLE);
    check_status("glitch");

    // 3: framing error, then a good frame clears it
    push_frame(8'h3C, 1'b0, 1'b0);
    do_read();
    push_frame(8'h55, 1'b1, 1'b0);
    do_read();

    // 4: overrun
    push_frame(8'h11, 1'b1, 1'b0);
    push_frame(8'h22, 1'b1, 1'b0);
    do_read();

    // 5: read on the completion edge; rda set beforehand
    push_frame(8'h5A, 1'b1, 1'b0);
    push_frame(8'h7E, 1'b1, 1'b1);
    #1;
    check_status("rd_collide");
    do_access(1'b0, IOADDR_DATA);
    do_access(1'b1, IOADDR_STATUS);
    do_access(1'b1, IOADDR_DB_HI);
    do_read();

    // 6: async reset in the middle of a 0xFF frame
    push_frame(8'hC3, 1'b1, 1'b0);
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        idle_clks(300);
        #1 rst = 1'b0;
        #1;
        m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
        check_status("async_reset");
        idle_clks(3);
        #1 rst = 1'b1;
      end
    join
    idle_clks(BIT_CLK);
    #1;
    check("post_reset_state", dbg_state, RX_IDLE);
    push_frame(8'h81, 1'b1, 1'b0);

    // randomized frames
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      logic       sb;
      bit         rd_done;
      b       = 8'($urandom_range(0, 255));
      sb      = ($urandom_range(0, 3) != 0);
      rd_done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) do_read();
      push_frame(b, sb, rd_done);
    end
    do_read();

    idle_clks(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // watchdog
  initial begin
    #600000;
    miscompares++;
    $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
